// File: rtl/trap_ctrl.sv
// trap_ctrl: commit-stage trap sequencer.
// Accepts one committing instruction per IDLE cycle, decides whether it raises
// an interrupt, an exception or an mret, then emits the CSR update strobes and
// the PC redirect over the following cycles while flushing the pipeline.
// Optional feature: define TRAP_VECTOR_EN to enable vectored interrupt entry
// (mtvec mode 2'b01 sends interrupts to base + 4*cause).
module trap_ctrl #(
   parameter logic [3:0] IRQ_CODE = 4'd11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        commit_valid_i,
   output logic        commit_ready_o,
   input  logic [31:0] commit_pc_i,
   input  logic [31:0] commit_instr_i,
   input  logic [31:0] commit_addr_i,
   input  logic        exc_illegal_i,
   input  logic        exc_ecall_i,
   input  logic        exc_ld_mis_i,
   input  logic        exc_st_mis_i,
   input  logic        is_mret_i,
   input  logic        irq_i,
   input  logic [31:0] mtvec_i,
   input  logic [31:0] mepc_i,
   input  logic        mstatus_ie_i,
   output logic        set_mcause_o,
   output logic        ie_type_o,
   output logic [3:0]  exception_code_o,
   output logic        set_mepc_o,
   output logic [31:0] epc_o,
   output logic        set_mtval_o,
   output logic [31:0] mtval_o,
   output logic        ecall_en_o,
   output logic        mret_en_o,
   output logic        flush_o,
   output logic        redirect_valid_o,
   output logic [31:0] redirect_pc_o
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      TRAP_WR  = 2'd1,
      TRAP_JMP = 2'd2,
      MRET_JMP = 2'd3
   } state_t;

   state_t      state_q;
   logic        commitReady_q;
   logic        setCause_q;
   logic        ieType_q;
   logic [3:0]  excCode_q;
   logic        setEpc_q;
   logic [31:0] epc_q;
   logic        setMtval_q;
   logic [31:0] mtval_q;
   logic        ecallEn_q;
   logic        mretEn_q;
   logic        flush_q;
   logic        redirValid_q;
   logic [31:0] redirPc_q;

   logic        trapTake_d;
   logic        mretTake_d;
   logic        ieType_d;
   logic [3:0]  excCode_d;
   logic [31:0] mtval_d;
   logic        ecall_d;
   logic [31:0] vecTarget_d;

   // Prioritised trap decision for the instruction presented in IDLE; only one cause wins.
   always_comb begin
      trapTake_d = 1'b0;
      mretTake_d = 1'b0;
      ieType_d   = 1'b0;
      excCode_d  = 4'd0;
      mtval_d    = 32'h0;
      ecall_d    = 1'b0;
      if (state_q == IDLE && commit_valid_i) begin
         if (irq_i && mstatus_ie_i) begin
            trapTake_d = 1'b1;
            ieType_d   = 1'b1;
            excCode_d  = IRQ_CODE;
         end else if (exc_illegal_i) begin
            trapTake_d = 1'b1;
            excCode_d  = 4'd2;
            mtval_d    = commit_instr_i;
         end else if (exc_ecall_i) begin
            trapTake_d = 1'b1;
            excCode_d  = 4'd11;
            ecall_d    = 1'b1;
         end else if (exc_ld_mis_i) begin
            trapTake_d = 1'b1;
            excCode_d  = 4'd4;
            mtval_d    = commit_addr_i;
         end else if (exc_st_mis_i) begin
            trapTake_d = 1'b1;
            excCode_d  = 4'd6;
            mtval_d    = commit_addr_i;
         end else if (is_mret_i) begin
            mretTake_d = 1'b1;
         end
      end
   end

`ifdef TRAP_VECTOR_EN
   // Trap entry target: vectored mode offsets interrupts by four bytes per cause code.
   always_comb begin
      vecTarget_d = {mtvec_i[31:2], 2'b00};
      if (mtvec_i[1:0] == 2'b01 && ieType_q)
         vecTarget_d = {mtvec_i[31:2], 2'b00} + {26'd0, excCode_q, 2'b00};
   end
`else
   logic unusedMode;
   assign unusedMode = ^mtvec_i[1:0];

   // Trap entry target: direct mode only, the mode bits are not consulted.
   always_comb begin
      vecTarget_d = {mtvec_i[31:2], 2'b00};
   end
`endif

   // Sequencer state and all registered outputs; strobes default low so each is a one-cycle pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         commitReady_q <= 1'b1;
         setCause_q    <= 1'b0;
         ieType_q      <= 1'b0;
         excCode_q     <= 4'd0;
         setEpc_q      <= 1'b0;
         epc_q         <= 32'h0;
         setMtval_q    <= 1'b0;
         mtval_q       <= 32'h0;
         ecallEn_q     <= 1'b0;
         mretEn_q      <= 1'b0;
         flush_q       <= 1'b0;
         redirValid_q  <= 1'b0;
         redirPc_q     <= 32'h0;
      end else begin
         setCause_q   <= 1'b0;
         setEpc_q     <= 1'b0;
         setMtval_q   <= 1'b0;
         ecallEn_q    <= 1'b0;
         mretEn_q     <= 1'b0;
         redirValid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (trapTake_d) begin
                  state_q       <= TRAP_WR;
                  commitReady_q <= 1'b0;
                  flush_q       <= 1'b1;
                  setCause_q    <= 1'b1;
                  setEpc_q      <= 1'b1;
                  setMtval_q    <= 1'b1;
                  ecallEn_q     <= ecall_d;
                  ieType_q      <= ieType_d;
                  excCode_q     <= excCode_d;
                  epc_q         <= commit_pc_i;
                  mtval_q       <= mtval_d;
               end else if (mretTake_d) begin
                  state_q       <= MRET_JMP;
                  commitReady_q <= 1'b0;
                  flush_q       <= 1'b1;
                  mretEn_q      <= 1'b1;
                  redirValid_q  <= 1'b1;
                  redirPc_q     <= mepc_i;
               end
            end
            TRAP_WR: begin
               state_q      <= TRAP_JMP;
               redirValid_q <= 1'b1;
               redirPc_q    <= vecTarget_d;
            end
            TRAP_JMP, MRET_JMP: begin
               state_q       <= IDLE;
               commitReady_q <= 1'b1;
               flush_q       <= 1'b0;
            end
            default: begin
               state_q       <= IDLE;
               commitReady_q <= 1'b1;
               flush_q       <= 1'b0;
            end
         endcase
      end
   end

   assign commit_ready_o   = commitReady_q;
   assign set_mcause_o     = setCause_q;
   assign ie_type_o        = ieType_q;
   assign exception_code_o = excCode_q;
   assign set_mepc_o       = setEpc_q;
   assign epc_o            = epc_q;
   assign set_mtval_o      = setMtval_q;
   assign mtval_o          = mtval_q;
   assign ecall_en_o       = ecallEn_q;
   assign mret_en_o        = mretEn_q;
   assign flush_o          = flush_q;
   assign redirect_valid_o = redirValid_q;
   assign redirect_pc_o    = redirPc_q;

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 The block SHALL have parameter IRQ_CODE, default 4'd11, the mcause exception code reported for the external interrupt.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, the reset: synchronous and active-high.
REQ-004 The block SHALL have ports commit_valid_i (input, 1) and commit_ready_o (output, 1): the commit-slot handshake.
REQ-005 The block SHALL have ports commit_pc_i (input, 32), commit_instr_i (input, 32) and commit_addr_i (input, 32): PC, instruction word and memory address of the committing instruction.
REQ-006 The block SHALL have 1-bit input flags exc_illegal_i, exc_ecall_i, exc_ld_mis_i, exc_st_mis_i and is_mret_i, and 1-bit input irq_i (level external interrupt).
REQ-007 The block SHALL have 32-bit inputs mtvec_i and mepc_i, and 1-bit input mstatus_ie_i, all read from the CSR file.
REQ-008 The block SHALL have outputs set_mcause_o (1), ie_type_o (1), exception_code_o (4), set_mepc_o (1), epc_o (32), set_mtval_o (1), mtval_o (32), ecall_en_o (1) and mret_en_o (1): the CSR update strobes.
REQ-009 The block SHALL have outputs flush_o (1), redirect_valid_o (1) and redirect_pc_o (32).

Function
REQ-010 The FSM SHALL have states IDLE, TRAP_WR, TRAP_JMP and MRET_JMP, and commit_ready_o SHALL be 1 only in IDLE.
REQ-011 A commit SHALL be accepted in IDLE when commit_valid_i=1; with no flag set and no taken interrupt, it retires and the FSM stays in IDLE.
REQ-012 An interrupt SHALL be taken only when irq_i & mstatus_ie_i & commit_valid_i in IDLE; the committing instruction is discarded.
REQ-013 Trap priority SHALL be: interrupt (ie=1, IRQ_CODE) > illegal (ie=0, 2) > ecall (11) > load misaligned (4) > store misaligned (6) > mret.
REQ-014 On a trap accepted at edge N, the FSM SHALL go IDLE->TRAP_WR; in cycle N+1 it pulses set_mcause_o, set_mepc_o, set_mtval_o and ecall_en_o for exactly one cycle, with epc_o=commit_pc_i latched at acceptance.
REQ-015 mtval_o SHALL be commit_instr_i for illegal, commit_addr_i for misaligned, and 0 for ecall or interrupt.
REQ-016 After TRAP_WR the FSM SHALL enter TRAP_JMP for one cycle (N+2), pulse redirect_valid_o with redirect_pc_o={mtvec_i[31:2],2'b00} sampled that cycle, then return to IDLE.
REQ-017 On mret at edge N, the FSM SHALL go IDLE->MRET_JMP; in cycle N+1 it pulses mret_en_o and redirect_valid_o together with redirect_pc_o=mepc_i, then returns to IDLE.
REQ-018 flush_o SHALL be 1 in every non-IDLE state, including the redirect cycle.
REQ-019 irq_i and all flags arriving while not in IDLE SHALL be ignored; a still-asserted irq_i is evaluated again on the first IDLE cycle.
REQ-020 Only one trap SHALL be raised per commit, even when multiple flags are set simultaneously.
REQ-021 Every strobe SHALL be a single-cycle pulse, and no two traps' strobes SHALL overlap.

Reset
REQ-022 With rst=1 at an edge, the state SHALL become IDLE and every output SHALL be 0 except commit_ready_o=1; epc_o, mtval_o and redirect_pc_o SHALL be 32'h0.
REQ-023 A reset asserted in any non-IDLE state SHALL abort the sequence with no further strobe or redirect emitted.

Configuration
REQ-024 With macro TRAP_VECTOR_EN defined, mtvec_i[1:0]==2'b01, and an interrupt trap, redirect_pc_o SHALL be {mtvec_i[31:2],2'b00}+4*exception_code; all other cases SHALL follow REQ-016.
REQ-025 With TRAP_VECTOR_EN undefined, redirect_pc_o SHALL always be {mtvec_i[31:2],2'b00}, and mtvec_i[1:0] SHALL be ignored.

Verification
REQ-026 The bench SHALL cover: illegal at pc=0x100, instr=0xFFFFFFFF, mtvec=0x80 -> cycle N+1: mcause {0,2}, epc 0x100, mtval 0xFFFFFFFF; cycle N+2: redirect 0x80.
REQ-027 The bench SHALL cover: ecall and ld_mis set together, pc=0x200 -> code 11 only, mtval 0, one ecall_en_o pulse.
REQ-028 The bench SHALL cover: irq_i=1, mstatus_ie_i=0 -> no trap; then mstatus_ie_i=1 -> ie_type 1, code 11, epc=commit_pc.
REQ-029 The bench SHALL cover: mret with mepc=0x344 -> cycle N+1: mret_en_o=1, redirect_valid_o=1, redirect_pc_o 0x344; commit_ready_o=0 for exactly 1 cycle.
REQ-030 The bench SHALL cover: rst asserted in TRAP_WR -> next cycle IDLE, and no redirect ever occurs.
REQ-031 The bench SHALL cover, with TRAP_VECTOR_EN defined: mtvec=0x101, interrupt -> redirect 0x12C; exception -> redirect 0x100.
